ref_block_reader: RTL

- Upstream neighbour of the engine; fetches the reference sequence from DRAM for one engine.
- Takes the reference address and length the engine publishes, then issues beat-granular DRAM read requests.
- Assembles the returned beats into 2*REF_LENGTH-bit reference blocks and delivers them over a valid/rdy handshake into the engine's reference-block input.
- Credit-based flow control guarantees the internal beat FIFO can never overflow.

---
 rtl/ref_block_reader_if.sv | 33 +++
 rtl/ref_block_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ref_block_reader_if.sv
// ============================================================================
// Module      : ref_block_reader_if
// Description : DRAM read channel and reference-block handshake bundle used by
//               ref_block_reader (master) and its DRAM/engine neighbours (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ref_block_reader_if #(
  parameter int REF_LENGTH = 256,
  parameter int DRAM_WIDTH = 128
);
  logic                    dram_rd_req_out;
  logic [24:0]             dram_rd_addr_out;
  logic                    dram_rd_gnt_in;
  logic [DRAM_WIDTH-1:0]   dram_rd_data_in;
  logic                    dram_rd_data_valid_in;
  logic [2*REF_LENGTH-1:0] ref_seq_block_out;
  logic                    ref_seq_block_valid_out;
  logic                    ref_seq_block_rdy_in;

  modport master (
    output dram_rd_req_out, dram_rd_addr_out, ref_seq_block_out, ref_seq_block_valid_out,
    input  dram_rd_gnt_in, dram_rd_data_in, dram_rd_data_valid_in, ref_seq_block_rdy_in
  );

  modport slave (
    input  dram_rd_req_out, dram_rd_addr_out, ref_seq_block_out, ref_seq_block_valid_out,
    output dram_rd_gnt_in, dram_rd_data_in, dram_rd_data_valid_in, ref_seq_block_rdy_in
  );
endinterface

`default_nettype wire

// File: rtl/ref_block_reader.sv
// ============================================================================
// Module      : ref_block_reader
// Description : Fetches reference blocks from DRAM beat by beat, assembles them
//               into 2*REF_LENGTH-bit blocks and hands them to the engine.
//               Optional starvation counter: define REF_READER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_block_reader #(
  parameter int REF_LENGTH = 256,
  parameter int DRAM_WIDTH = 128,
  parameter int FIFO_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [24:0]        ref_addr_in,
  input  logic [24:0]        ref_length_in,
  input  logic               ref_info_valid_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [31:0]        stat_starve_cycles_out,
  ref_block_reader_if.master bus
);

  localparam int BEATS    = 2 * REF_LENGTH / DRAM_WIDTH;
  localparam int PTR_W    = $clog2(FIFO_BEATS);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ASM_W    = $clog2(BEATS + 1);
  localparam int BLOCK_W  = 2 * REF_LENGTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [24:0]           r_req_addr;
  logic [29:0]           r_beats_left;
  logic [24:0]           r_blocks_left;
  logic                  r_busy;
  logic                  r_done;

  logic [CNT_W-1:0]      r_credit;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_fifo_cnt;
  logic [DRAM_WIDTH-1:0] r_fifo_mem [FIFO_BEATS];

  logic [ASM_W-1:0]      r_asm_cnt;
  logic [BLOCK_W-1:0]    r_block;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_handshake;
  logic                  w_push;
  logic                  w_pop;
  logic [29:0]           w_length_beats;
  logic [ASM_W-1:0]      w_slot;
  logic [DRAM_WIDTH-1:0] w_fifo_head;
  logic [BLOCK_W-1:0]    w_block_next;

  // The done cycle itself blocks a new accept so a level-held valid yields pulses.
  assign w_accept       = (r_state == S_IDLE) && !r_done && ref_info_valid_in;
  assign w_req          = (r_state == S_FETCH) && (r_credit < CNT_W'(FIFO_BEATS));
  assign w_grant        = w_req && bus.dram_rd_gnt_in;
  assign w_handshake    = r_valid && bus.ref_seq_block_rdy_in;
  assign w_push         = bus.dram_rd_data_valid_in;
  assign w_pop          = (r_fifo_cnt != '0) && ((r_asm_cnt != ASM_W'(BEATS)) || w_handshake);
  assign w_length_beats = 30'(ref_length_in) * 30'(BEATS);
  assign w_slot         = w_handshake ? '0 : r_asm_cnt;
  assign w_fifo_head    = r_fifo_mem[r_rd_ptr];

  always_comb begin
    w_block_next = w_handshake ? '0 : r_block;
    if (w_pop) begin
      w_block_next[w_slot*DRAM_WIDTH +: DRAM_WIDTH] = w_fifo_head;
    end
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_req_addr    <= '0;
      r_beats_left  <= '0;
      r_blocks_left <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_handshake) begin
        r_blocks_left <= r_blocks_left - 25'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_addr    <= ref_addr_in;
            r_beats_left  <= w_length_beats;
            r_blocks_left <= ref_length_in;
            if (ref_length_in == 25'd0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_grant) begin
            r_req_addr   <= r_req_addr + 25'd1;
            r_beats_left <= r_beats_left - 30'd1;
            if (r_beats_left == 30'd1) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_handshake && (r_blocks_left == 25'd1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beat storage is left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= bus.dram_rd_data_in;
    end
  end

  // Credit, FIFO bookkeeping and block assembler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_asm_cnt  <= '0;
      r_block    <= '0;
      r_valid    <= 1'b0;
    end else begin
      case ({w_grant, w_pop})
        2'b10:   r_credit <= r_credit + CNT_W'(1);
        2'b01:   r_credit <= r_credit - CNT_W'(1);
        default: r_credit <= r_credit;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      r_block <= w_block_next;
      if (w_pop) begin
        r_asm_cnt <= w_slot + ASM_W'(1);
        if (w_slot == ASM_W'(BEATS - 1)) begin
          r_valid <= 1'b1;
        end else if (w_handshake) begin
          r_valid <= 1'b0;
        end
      end else if (w_handshake) begin
        r_asm_cnt <= '0;
        r_valid   <= 1'b0;
      end
    end
  end

`ifdef REF_READER_STATS_EN
  logic [31:0] r_starve_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_accept) begin
      r_starve_cnt <= '0;
    end else if (r_busy && !r_valid && (r_starve_cnt != 32'hFFFF_FFFF)) begin
      r_starve_cnt <= r_starve_cnt + 32'd1;
    end
  end

  assign stat_starve_cycles_out = r_starve_cnt;
`else
  assign stat_starve_cycles_out = 32'd0;
`endif

`ifndef SYNTHESIS
  // Every returning beat must correspond to a granted, not yet popped request.
  always @(posedge clk) begin
    if (rst && w_push) begin
      assert (r_credit != '0);
    end
  end
`endif

  assign busy_out                    = r_busy;
  assign done_out                    = r_done;
  assign bus.dram_rd_req_out         = w_req;
  assign bus.dram_rd_addr_out        = r_req_addr;
  assign bus.ref_seq_block_out       = r_block;
  assign bus.ref_seq_block_valid_out = r_valid;

endmodule

`default_nettype wire
